// File: rtl/stat_dump_pkg.sv
// stat_pkg: shared FSM type, ASCII constants and character counts for stat_dump.
// Defining STAT_DUMP_HEADER_EN prefixes every dump with "ST:".
package stat_pkg;
    localparam int CLK_DIV_DEF = 868;
    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] HDR_S = 8'h53;
    localparam logic [7:0] HDR_T = 8'h54;
    localparam logic [7:0] HDR_C = 8'h3A;
    localparam int BODY_CHARS = 46;
`ifdef STAT_DUMP_HEADER_EN
    localparam int HDR_CHARS = 3;
`else
    localparam int HDR_CHARS = 0;
`endif
    localparam int N_CHARS = HDR_CHARS + BODY_CHARS;
    typedef enum logic [1:0] {IDLE, START_BIT, DATA, STOP} state_t;
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/stat_dump_if.sv
// stat_dump_if: counter inputs, dump request and UART/status outputs of stat_dump.
interface stat_dump_if;
    logic        start;
    logic [31:0] total_cycles;
    logic [31:0] uncondi_num;
    logic [31:0] condi_num;
    logic [31:0] condi_suc_num;
    logic [31:0] syscall_out;
    logic        tx;
    logic        busy;
    logic        done;
    modport master (output start, total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out,
                    input tx, busy, done);
    modport slave  (input start, total_cycles, uncondi_num, condi_num, condi_suc_num, syscall_out,
                    output tx, busy, done);
endinterface

// File: rtl/stat_dump_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte framer; accepts the next byte in the last stop-bit cycle so frames abut.
module uart_tx_byte
    import stat_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       eob_o,
    output logic       tx_o
);
    state_t      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  sh_q, sh_d;
    logic        tx_q, tx_d;
    logic        bit_end;
    assign bit_end = baud_q == 16'(CLK_DIV - 1);
    assign eob_o   = state_q == STOP && bit_end;
    assign ready_o = state_q == IDLE || eob_o;
    assign tx_o    = tx_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == IDLE || bit_end) ? 16'd0 : baud_q + 16'd1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        if (valid_i && ready_o) begin
            state_d = START_BIT;
            sh_d    = data_i;
            tx_d    = 1'b0;
        end else if (bit_end) begin
            case (state_q)
                START_BIT: begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                end
                DATA: begin
                    state_d = bit_q == 3'd7 ? STOP : DATA;
                    bit_d   = bit_q + 3'd1;
                    tx_d    = bit_q == 3'd7 ? 1'b1 : sh_q[0];
                    sh_d    = {1'b0, sh_q[7:1]};
                end
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: rtl/stat_dump.sv
// stat_dump: snapshots five 32-bit counters and streams them as hex text over a UART.
// Defining STAT_DUMP_HEADER_EN prefixes each dump with "ST:".
module stat_dump
    import stat_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEF
) (
    input  logic        clk,
    input  logic        rst,
    stat_dump_if.slave  bus
);
    logic [4:0][31:0] cnt_in, snap_q, snap_d, src;
    logic             busy_q, busy_d, done_q, done_d;
    logic [5:0]       idx_q, idx_d, rel;
    logic [2:0]       word_sel;
    logic [3:0]       pos, nib;
    logic [31:0]      word;
    logic [7:0]       ch;
    logic             valid, ready, eob;
    assign cnt_in = {bus.syscall_out, bus.condi_suc_num, bus.condi_num, bus.uncondi_num, bus.total_cycles};
    // Character 0 is launched on the accepting edge, so it is built from the live inputs.
    assign src   = busy_q ? snap_q : cnt_in;
    assign valid = busy_q ? idx_q != 6'(N_CHARS) : bus.start;
    always_comb begin
        rel      = idx_q - 6'(HDR_CHARS);
        word_sel = 3'(rel / 6'd9);
        pos      = 4'(rel % 6'd9);
        word     = src[word_sel];
        nib      = 4'(word >> {~pos[2:0], 2'b00});
        ch       = rel == 6'(BODY_CHARS - 1) ? ASCII_LF :
                   pos == 4'd8 ? (word_sel == 3'd4 ? ASCII_CR : ASCII_SP) : hex_ascii(nib);
`ifdef STAT_DUMP_HEADER_EN
        ch       = idx_q == 6'd0 ? HDR_S : idx_q == 6'd1 ? HDR_T : idx_q == 6'd2 ? HDR_C : ch;
`endif
    end
    always_comb begin
        busy_d = busy_q;
        done_d = 1'b0;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (!busy_q) begin
            if (bus.start) begin
                busy_d = 1'b1;
                idx_d  = 6'd1;
                snap_d = cnt_in;
            end
        end else if (eob && idx_q == 6'(N_CHARS)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            idx_d  = 6'd0;
        end else if (valid && ready) begin
            idx_d  = idx_q + 6'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            idx_q  <= '0;
            snap_q <= '0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
        end
    end
    uart_tx_byte #(.CLK_DIV(CLK_DIV)) u_tx (
        .clk     (clk),
        .rst     (rst),
        .data_i  (ch),
        .valid_i (valid),
        .ready_o (ready),
        .eob_o   (eob),
        .tx_o    (bus.tx)
    );
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: doc/stat_dump.md
STAT_DUMP -- requirements
Module: stat_dump

Interface
REQ-001 Parameter CLK_DIV, default 868, clk cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 Reset rst, synchronous, active-high; clock clk.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  single-cycle request to dump statistics.
REQ-006 total_cycles  input  32  statistic counter 0.
REQ-007 uncondi_num  input  32  statistic counter 1.
REQ-008 condi_num  input  32  statistic counter 2.
REQ-009 condi_suc_num  input  32  statistic counter 3.
REQ-010 syscall_out  input  32  statistic counter 4.
REQ-011 tx  output  1  UART serial line, 8N1, idle high.
REQ-012 busy  output  1  high while a dump is in progress.
REQ-013 done  output  1  one-cycle pulse at dump completion.

Function
REQ-014 When start is high in a cycle with busy low, the block SHALL snapshot all five counters into internal registers on that edge; later input changes SHALL NOT affect the dump.
REQ-015 busy SHALL rise the cycle after start is accepted and remain high until done pulses.
REQ-016 start while busy high SHALL be ignored; no queuing.
REQ-017 Dump order SHALL be counter 0..4; each counter as 8 uppercase ASCII hex digits, most significant nibble first (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
REQ-018 Counters 0-3 SHALL each be followed by 0x20; counter 4 SHALL be followed by 0x0D, 0x0A; total 46 characters.
REQ-019 Each character SHALL be framed as start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly CLK_DIV cycles; 10*CLK_DIV cycles per character.
REQ-020 Characters SHALL be back-to-back, no idle gap between a stop bit and the next start bit.
REQ-021 The first start bit SHALL drive tx low starting the cycle after start is accepted.
REQ-022 done SHALL pulse high for one cycle in the cycle after the final stop bit ends; busy SHALL fall in that same cycle; a new start SHALL be accepted that cycle or later.
REQ-023 FSM states: IDLE, START_BIT, DATA, STOP; IDLE->START_BIT on accepted start; START_BIT->DATA after CLK_DIV cycles; DATA->STOP after 8 bits; STOP->START_BIT if characters remain, else IDLE with done.
REQ-024 Baud counter SHALL be 16 bits, count 0..CLK_DIV-1, and reload to 0 at each bit boundary.
REQ-025 Character index SHALL be 6 bits and never wrap within a dump.

Reset
REQ-026 rst SHALL force tx=1, busy=0, done=0, FSM=IDLE, baud and character counters=0, snapshot registers=0.
REQ-027 rst mid-dump SHALL abort immediately; tx high the next cycle; no done pulse.
REQ-028 rst and start in the same cycle: rst wins, start discarded.

Configuration
REQ-029 Macro STAT_DUMP_HEADER_EN defined: each dump SHALL be prefixed by 0x53 0x54 0x3A ("ST:"), total 49 characters, done timing shifted by 30*CLK_DIV cycles.
REQ-030 Macro undefined: no header, exactly 46 characters per dump.

Structure
REQ-031 Shared package stat_pkg SHALL hold the FSM state type, ASCII constants (space, CR, LF, header bytes), character-count constants, and CLK_DIV default.
REQ-032 One sub-module uart_tx_byte (byte in, valid/ready, tx out, CLK_DIV parameter) SHALL implement framing; stat_dump SHALL own snapshot, hex conversion, and sequencing.

Verification (CLK_DIV=4, macro undefined unless stated)
REQ-033 Inputs 0x0000002A,0x3,0x10,0x7,0xDEADBEEF; pulse start -> decoded UART stream "0000002A 00000003 00000010 00000007 DEADBEEF\r\n", done exactly 1840 cycles after the start edge.
REQ-034 Change all inputs to 0xFFFFFFFF one cycle after start -> stream still carries the original snapshot values.
REQ-035 Second start pulse at cycle 100 of a dump -> ignored; exactly 46 characters and one done pulse.
REQ-036 rst at cycle 500 of a dump -> tx=1, busy=0 next cycle, done never pulses; a new start then yields a complete correct dump.
REQ-037 STAT_DUMP_HEADER_EN defined, all inputs 0 -> "ST:00000000 00000000 00000000 00000000 00000000\r\n", done 1960 cycles after start.
REQ-038 Measure tx low width of first start bit -> exactly 4 cycles; each character exactly 40 cycles, no gaps.
